leaf_rand_pool: RTL and testbench



---
 rtl/leaf_rand_pool_pkg.sv | 19 +
 rtl/leaf_queue.sv | 74 +++++++
 rtl/leaf_rand_pool.sv | 71 +++++++
 tb/tb_leaf_rand_pool.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_rand_pool_pkg.sv
`default_nettype none
// ============================================================================
// Module   : leaf_rand_pool_pkg
// Purpose  : Shared constants and width helpers for the leaf random pool.
// Revision : 1.0  initial release
// ============================================================================
package leaf_rand_pool_pkg;

   localparam int c_RAND_WIDTH = 32;
   localparam int c_ORAML      = 20;
   localparam int c_DEPTH      = 4;

   // Bits needed to hold any value in 0..maxVal, never less than one.
   function automatic int cntWidth(input int maxVal);
      return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/leaf_queue.sv
`default_nettype none
// ============================================================================
// Module   : leaf_queue
// Purpose  : Depth x Width register FIFO; full is judged before the pop.
// Revision : 1.0  initial release
// ============================================================================
module leaf_queue
   import leaf_rand_pool_pkg::*;
#(
   parameter int Width = 20,
   parameter int Depth = 4
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic                         Push,
   input  logic [Width-1:0]             PushData,
   input  logic                         Pop,
   output logic [Width-1:0]             HeadData,
   output logic                         NotEmpty,
   output logic                         Full,
   output logic [cntWidth(Depth)-1:0]   Count
);

   localparam int                         c_PTR_W    = $clog2(Depth);
   localparam int                         c_CNT_W    = cntWidth(Depth);
   localparam logic [c_PTR_W-1:0]         c_LAST_PTR = c_PTR_W'(Depth - 1);
   localparam logic [c_CNT_W-1:0]         c_FULL_CNT = c_CNT_W'(Depth);

   logic [Width-1:0]   r_mem [Depth];
   logic [c_PTR_W-1:0] r_rdPtr;
   logic [c_PTR_W-1:0] r_wrPtr;
   logic [c_CNT_W-1:0] r_count;

   logic w_push;
   logic w_pop;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [c_PTR_W-1:0] nextPtr(input logic [c_PTR_W-1:0] ptr);
      return (ptr == c_LAST_PTR) ? '0 : ptr + 1'b1;
   endfunction

   assign Full     = (r_count == c_FULL_CNT);
   assign NotEmpty = (r_count != '0);
   assign w_push   = Push && !Full;
   assign w_pop    = Pop && NotEmpty;
   assign HeadData = r_mem[r_rdPtr];
   assign Count    = r_count;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < Depth; i++) begin
            r_mem[i] <= '0;
         end
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wrPtr] <= PushData;
            r_wrPtr        <= nextPtr(r_wrPtr);
         end
         if (w_pop) begin
            r_rdPtr <= nextPtr(r_rdPtr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/leaf_rand_pool.sv
`default_nettype none
// ============================================================================
// Module   : leaf_rand_pool
// Purpose  : Repacks PRNG words into ORAML-bit leaf labels, each bit used once.
// Revision : 1.0  initial release
// ============================================================================
module leaf_rand_pool
   import leaf_rand_pool_pkg::*;
#(
   parameter int RandWidth = c_RAND_WIDTH,
   parameter int ORAML     = c_ORAML,
   parameter int Depth     = c_DEPTH
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic                         RandInValid,
   output logic                         RandInReady,
   input  logic [RandWidth-1:0]         RandIn,
   input  logic                         LeafOutReady,
   output logic                         LeafOutValid,
   output logic [ORAML-1:0]             LeafOut,
   output logic [cntWidth(Depth)-1:0]   LeafCount
);

   // Worst case is ORAML-1 leftover bits plus one fresh word.
   localparam int                     c_POOL_W   = RandWidth + ORAML - 1;
   localparam int                     c_BC_W     = cntWidth(c_POOL_W);
   localparam logic [c_BC_W-1:0]      c_ORAML_BC = c_BC_W'(ORAML);
   localparam logic [c_BC_W-1:0]      c_RAND_BC  = c_BC_W'(RandWidth);

   logic [c_POOL_W-1:0] r_pool;
   logic [c_BC_W-1:0]   r_bitCount;

   logic w_accept;
   logic w_extract;
   logic w_queueFull;

   assign RandInReady = !Reset && (r_bitCount < c_ORAML_BC);
   assign w_accept    = RandInValid && RandInReady;
   assign w_extract   = (r_bitCount >= c_ORAML_BC) && !w_queueFull;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_pool     <= '0;
         r_bitCount <= '0;
      end else if (w_accept) begin
         r_pool     <= r_pool | (c_POOL_W'(RandIn) << r_bitCount);
         r_bitCount <= r_bitCount + c_RAND_BC;
      end else if (w_extract) begin
         r_pool     <= r_pool >> ORAML;
         r_bitCount <= r_bitCount - c_ORAML_BC;
      end
   end

   leaf_queue #(
      .Width (ORAML),
      .Depth (Depth)
   ) u_leafQueue (
      .Clock    (Clock),
      .Reset    (Reset),
      .Push     (w_extract),
      .PushData (r_pool[ORAML-1:0]),
      .Pop      (LeafOutReady),
      .HeadData (LeafOut),
      .NotEmpty (LeafOutValid),
      .Full     (w_queueFull),
      .Count    (LeafCount)
   );

endmodule
`default_nettype wire

// File: tb/tb_leaf_rand_pool.sv
`default_nettype none
// ============================================================================
// Module   : tb_leaf_rand_pool
// Purpose  : Scoreboard bench for leaf_rand_pool (ORAML=20 and ORAML=40).
// Revision : 1.0  initial release
// ============================================================================
module tb_leaf_rand_pool;

   logic Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic        Reset;
   logic        RandInValid, RandInReady, LeafOutReady, LeafOutValid;
   logic [31:0] RandIn;
   logic [19:0] LeafOut;
   logic [2:0]  LeafCount;

   logic        RandInValidB, RandInReadyB, LeafOutReadyB, LeafOutValidB;
   logic [31:0] RandInB;
   logic [39:0] LeafOutB;
   logic [2:0]  LeafCountB;

   int nChecks = 0;
   int nPass   = 0;

   logic [63:0] expA[$];
   logic [63:0] expB[$];

   leaf_rand_pool #(.RandWidth(32), .ORAML(20), .Depth(4)) dut (
      .Clock(Clock), .Reset(Reset),
      .RandInValid(RandInValid), .RandInReady(RandInReady), .RandIn(RandIn),
      .LeafOutReady(LeafOutReady), .LeafOutValid(LeafOutValid),
      .LeafOut(LeafOut), .LeafCount(LeafCount)
   );

   leaf_rand_pool #(.RandWidth(32), .ORAML(40), .Depth(4)) dutB (
      .Clock(Clock), .Reset(Reset),
      .RandInValid(RandInValidB), .RandInReady(RandInReadyB), .RandIn(RandInB),
      .LeafOutReady(LeafOutReadyB), .LeafOutValid(LeafOutValidB),
      .LeafOut(LeafOutB), .LeafCount(LeafCountB)
   );

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endfunction

   function automatic void failNote(input string name);
      nChecks++;
      $display("FAIL %s: bound expired", name);
   endfunction

   // Monitors: a pop happens at the next rising edge whenever valid && ready here.
   always @(negedge Clock) begin
      if (!Reset && LeafOutValid && LeafOutReady) begin
         if (expA.size() == 0) begin
            nChecks++;
            $display("FAIL leafA_unexpected: got 0x%0h, expected none", LeafOut);
         end else begin
            chk("leafA", {44'd0, LeafOut}, expA.pop_front());
         end
      end
      if (!Reset && LeafOutValidB && LeafOutReadyB) begin
         if (expB.size() == 0) begin
            nChecks++;
            $display("FAIL leafB_unexpected: got 0x%0h, expected none", LeafOutB);
         end else begin
            chk("leafB", {24'd0, LeafOutB}, expB.pop_front());
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge Clock);
         #1;
      end
   endtask

   // Returns 1 ns after the edge on which the word was taken.
   task automatic sendA(input logic [31:0] w);
      bit ok = 1'b0;
      int n  = 0;
      RandIn      = w;
      RandInValid = 1'b1;
      while (!ok && n < 50) begin
         @(negedge Clock);
         ok = RandInReady;
         @(posedge Clock);
         #1;
         n++;
      end
      RandInValid = 1'b0;
      if (!ok) failNote("sendA_timeout");
   endtask

   task automatic sendB(input logic [31:0] w);
      bit ok = 1'b0;
      int n  = 0;
      RandInB      = w;
      RandInValidB = 1'b1;
      while (!ok && n < 50) begin
         @(negedge Clock);
         ok = RandInReadyB;
         @(posedge Clock);
         #1;
         n++;
      end
      RandInValidB = 1'b0;
      if (!ok) failNote("sendB_timeout");
   endtask

   task automatic pulseReset();
      Reset = 1'b1;
      expA.delete();
      expB.delete();
      cyc(2);
      Reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset         = 1'b1;
      RandInValid   = 1'b0;
      RandIn        = '0;
      LeafOutReady  = 1'b1;
      RandInValidB  = 1'b0;
      RandInB       = '0;
      LeafOutReadyB = 1'b1;
      cyc(3);

      // Reset state
      chk("ready_in_reset", RandInReady, 0);
      chk("valid_in_reset", LeafOutValid, 0);
      chk("leaf_in_reset", LeafOut, 0);
      chk("count_in_reset", LeafCount, 0);
      Reset = 1'b0;
      #1;
      chk("ready_after_reset", RandInReady, 1);
      cyc(1);
      chk("idle_valid", LeafOutValid, 0);
      chk("idle_count", LeafCount, 0);

      // Two words repacked into three leaves with free-running consumer
      expA.push_back(64'hDBEEF);
      expA.push_back(64'h78DEA);
      expA.push_back(64'h23456);
      sendA(32'hDEADBEEF);
      chk("t1_bc32", dut.r_bitCount, 32);
      chk("t1_ready_bc32", RandInReady, 0);
      cyc(1);
      chk("t1_bc12", dut.r_bitCount, 12);
      chk("t1_ready_bc12", RandInReady, 1);
      sendA(32'h12345678);
      chk("t1_bc44", dut.r_bitCount, 44);
      chk("t1_ready_bc44", RandInReady, 0);
      cyc(1);
      chk("t1_bc24", dut.r_bitCount, 24);
      chk("t1_ready_bc24", RandInReady, 0);
      cyc(1);
      chk("t1_bc4", dut.r_bitCount, 4);
      chk("t1_ready_bc4", RandInReady, 1);
      chk("t1_pool", dut.r_pool, 64'h1);
      cyc(3);
      chk("t1_drained", expA.size(), 0);
      chk("t1_count0", LeafCount, 0);

      // Back-pressure: queue saturates, pool stalls, then drains in order
      pulseReset();
      LeafOutReady = 1'b0;
      expA.push_back(64'h11111);
      expA.push_back(64'h22111);
      expA.push_back(64'h22222);
      expA.push_back(64'h33332);
      expA.push_back(64'h43333);
      expA.push_back(64'h44444);
      expA.push_back(64'h55544);
      expA.push_back(64'h55555);
      sendA(32'h11111111);
      sendA(32'h22222222);
      sendA(32'h33333333);
      sendA(32'h44444444);
      cyc(3);
      chk("t2_count_sat", LeafCount, 4);
      chk("t2_bc_stall", dut.r_bitCount, 48);
      chk("t2_ready_stall", RandInReady, 0);
      chk("t2_valid", LeafOutValid, 1);
      chk("t2_head_stable", LeafOut, 20'h11111);
      LeafOutReady = 1'b1;
      sendA(32'h55555555);
      cyc(12);
      chk("t2_drained", expA.size(), 0);
      chk("t2_count0", LeafCount, 0);
      chk("t2_bc0", dut.r_bitCount, 0);

      // Simultaneous push and pop at LeafCount=2
      pulseReset();
      LeafOutReady = 1'b0;
      expA.push_back(64'hDBEEF);
      expA.push_back(64'h78DEA);
      expA.push_back(64'h23456);
      sendA(32'hDEADBEEF);
      sendA(32'h12345678);
      cyc(1);
      chk("t3_count2_pre", LeafCount, 2);
      LeafOutReady = 1'b1;
      cyc(1);
      LeafOutReady = 1'b0;
      chk("t3_count2_post", LeafCount, 2);
      chk("t3_bc4", dut.r_bitCount, 4);
      chk("t3_head", LeafOut, 20'h78DEA);
      LeafOutReady = 1'b1;
      cyc(4);
      chk("t3_drained", expA.size(), 0);
      chk("t3_count0", LeafCount, 0);

      // Reset with partial pool and queued leaves discards them all
      pulseReset();
      LeafOutReady = 1'b0;
      sendA(32'hDEADBEEF);
      sendA(32'h12345678);
      cyc(3);
      chk("t4_count3_pre", LeafCount, 3);
      pulseReset();
      chk("t4_count_cleared", LeafCount, 0);
      chk("t4_valid_cleared", LeafOutValid, 0);
      chk("t4_bc_cleared", dut.r_bitCount, 0);
      LeafOutReady = 1'b1;
      expA.push_back(64'h00001);
      sendA(32'h00000001);
      cyc(3);
      chk("t4_bc12", dut.r_bitCount, 12);
      chk("t4_drained", expA.size(), 0);

      // Wide leaf spanning two words
      expB.push_back(64'h55AAAAAAAA);
      sendB(32'hAAAAAAAA);
      chk("t5_bc32", dutB.r_bitCount, 32);
      sendB(32'h55555555);
      chk("t5_bc64", dutB.r_bitCount, 64);
      cyc(1);
      chk("t5_bc24", dutB.r_bitCount, 24);
      cyc(3);
      chk("t5_drained", expB.size(), 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
